// File: rtl/szukanie_bitu_pkg.sv
// Shared definitions for the lowest-set-bit finder: FSM state type and default operand width.
package szukanie_bitu_pkg;

    localparam int DEFAULT_BITS = 32;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

endpackage

// File: rtl/szukanie_bitu.sv
// Sequential one-hot-to-index encoder: scans the operand LSB-first, one bit per clock,
// and reports the index of the lowest set bit (or an error for an all-zero word).
module szukanie_bitu
    import szukanie_bitu_pkg::*;
#(
    parameter int BITS = DEFAULT_BITS
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic signed [BITS-1:0] i_arg_A,
    output logic signed [BITS-1:0] o_result,
    output logic                   o_error,
    output logic                   o_busy,
    output logic                   o_valid
);

    localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;
    localparam logic [CW-1:0] LAST_INDEX = CW'(BITS - 1);

    state_t          state;
    logic [BITS-1:0] shift_reg;
    logic [CW-1:0]   index;

    assign o_busy = (state != IDLE);

    // The counter stops at BITS-1, where an all-zero word is declared instead of wrapping.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            index     <= '0;
            o_result  <= '0;
            o_error   <= 1'b0;
            o_valid   <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        shift_reg <= $unsigned(i_arg_A);
                        index     <= '0;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    if (shift_reg[0]) begin
                        o_result <= {{(BITS - CW){1'b0}}, index};
                        o_error  <= 1'b0;
                        o_valid  <= 1'b1;
                        state    <= DONE;
                    end else if (index == LAST_INDEX) begin
                        o_result <= '0;
                        o_error  <= 1'b1;
                        o_valid  <= 1'b1;
                        state    <= DONE;
                    end else begin
                        shift_reg <= shift_reg >> 1;
                        index     <= index + CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_szukanie_bitu.sv
// Self-checking bench for szukanie_bitu (BITS=32): directed requests with a scoreboard of
// expected index/error/latency, plus reset-abort and ignored-start scenarios.
module tb_szukanie_bitu;

    localparam int BITS = 32;

    typedef struct {
        logic [31:0] result;
        logic        error;
        int          latency;
    } exp_t;

    logic                   clk;
    logic                   rst;
    logic                   start;
    logic signed [BITS-1:0] arg_a;
    logic signed [BITS-1:0] result;
    logic                   error;
    logic                   busy;
    logic                   valid;

    int   vectors;
    int   miscompares;
    exp_t sb[$];

    szukanie_bitu #(.BITS(BITS)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_start  (start),
        .i_arg_A  (arg_a),
        .o_result (result),
        .o_error  (error),
        .o_busy   (busy),
        .o_valid  (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: lowest set bit found by scanning from the top down, latency counted from the start edge.
    function automatic exp_t model(input logic [31:0] a);
        exp_t e;
        e.result  = 32'd0;
        e.error   = 1'b1;
        e.latency = BITS + 1;
        for (int i = BITS - 1; i >= 0; i--) begin
            if (a[i]) begin
                e.result  = 32'(i);
                e.error   = 1'b0;
                e.latency = i + 2;
            end
        end
        return e;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drives one start pulse so that i_start is sampled on the next edge; returns at the negedge after it.
    task automatic apply_stimulus(input logic [31:0] a, input bit expect_result);
        @(negedge clk);
        start = 1'b1;
        arg_a = a;
        if (expect_result) sb.push_back(model(a));
        @(negedge clk);
        start = 1'b0;
        arg_a = $urandom;
    endtask

    task automatic wait_result(input string tag, input int first_edge);
        exp_t        e;
        int          n;
        bit          seen;
        bit          busy_ok;
        logic [31:0] held;
        n       = first_edge;
        seen    = 1'b0;
        busy_ok = 1'b1;
        while (!seen && n <= 40) begin
            if (valid === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (busy !== 1'b1) busy_ok = 1'b0;
                @(negedge clk);
                n++;
            end
        end
        check_output({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_output({tag, "_valid_seen"}, 32'(seen), 32'd1);
            check_output({tag, "_busy_during"}, 32'(busy_ok), 32'd1);
            if (seen) begin
                check_output({tag, "_latency"}, 32'(n), 32'(e.latency));
                check_output({tag, "_result"}, result, e.result);
                check_output({tag, "_error"}, 32'(error), 32'(e.error));
                check_output({tag, "_busy_done"}, 32'(busy), 32'd1);
                held = result;
                @(negedge clk);
                check_output({tag, "_valid_pulse"}, 32'(valid), 32'd0);
                check_output({tag, "_busy_idle"}, 32'(busy), 32'd0);
                check_output({tag, "_result_held"}, result, held);
            end
        end
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        int pulses;
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (valid === 1'b1) pulses++;
        end
        check_output({tag, "_no_valid"}, 32'(pulses), 32'd0);
    endtask

    initial begin
        logic [31:0] r;
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        start       = 1'b0;
        arg_a       = '0;

        repeat (2) @(negedge clk);
        check_output("reset_result", result, 32'd0);
        check_output("reset_error", 32'(error), 32'd0);
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_valid", 32'(valid), 32'd0);
        rst = 1'b0;

        apply_stimulus(32'h0000_0001, 1'b1);
        wait_result("bit0", 1);

        apply_stimulus(32'h8000_0050, 1'b1);
        wait_result("bit4", 1);

        apply_stimulus(32'h8000_0000, 1'b1);
        wait_result("bit31", 1);

        apply_stimulus(32'h0000_0000, 1'b1);
        wait_result("zero", 1);

        // A second start during the scan and a changing operand must both be ignored.
        apply_stimulus(32'h0000_0100, 1'b1);
        @(negedge clk);
        start = 1'b1;
        arg_a = 32'h0000_0001;
        @(negedge clk);
        start = 1'b0;
        arg_a = 32'hFFFF_FFFF;
        wait_result("ignored_start", 3);
        expect_quiet("ignored_start", 40);

        // Reset in the middle of a scan aborts it silently.
        apply_stimulus(32'h0001_0000, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_output("abort_result", result, 32'd0);
        check_output("abort_error", 32'(error), 32'd0);
        check_output("abort_busy", 32'(busy), 32'd0);
        check_output("abort_valid", 32'(valid), 32'd0);
        expect_quiet("abort", 30);
        apply_stimulus(32'h0000_0002, 1'b1);
        wait_result("after_abort", 1);

        // Start coinciding with reset is dropped.
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        arg_a = 32'h0000_0004;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check_output("start_with_rst_busy", 32'(busy), 32'd0);
        expect_quiet("start_with_rst", 10);

        for (int i = 0; i < 4; i++) begin
            r = $urandom | 32'h1;
            r = r << $urandom_range(0, 31);
            if (r == 32'd0) r = 32'h0000_0400;
            apply_stimulus(r, 1'b1);
            wait_result($sformatf("rand%0d", i), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/szukanie_bitu.md
SZUKANIE_BITU -- requirements
Module: szukanie_bitu

Interface
REQ-001 SHALL have parameter BITS, default 32, operand and result width.
REQ-002 SHALL have port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port i_arg_A  input  BITS (signed)  word to scan; sampled with i_start.
REQ-006 SHALL have port o_result  output  BITS (signed)  index of lowest set bit of i_arg_A, zero-extended.
REQ-007 SHALL have port o_error  output  1  high when the scanned word was all zeros.
REQ-008 SHALL have port o_busy  output  1  high whenever state is not IDLE.
REQ-009 SHALL have port o_valid  output  1  one-cycle pulse marking o_result/o_error as new.

Function
REQ-010 SHALL implement the inverse of the set-bit unit: a one-hot-to-index encoder that finds the lowest set bit of i_arg_A.
REQ-011 SHALL implement an FSM with states IDLE, SCAN, DONE.
REQ-012 IDLE with i_start=1 SHALL load a BITS-wide shift register with i_arg_A, clear the index counter to 0 and enter SCAN.
REQ-013 SCAN SHALL test shift-register bit 0 each cycle: if 1, load o_result=counter, o_error=0, enter DONE.
REQ-014 SCAN with bit 0 = 0 and counter = BITS-1 SHALL load o_result=0, o_error=1, enter DONE.
REQ-015 SCAN otherwise SHALL shift the register right by one (zero fill) and increment the counter.
REQ-016 DONE SHALL assert o_valid for exactly one cycle, then return to IDLE unconditionally.
REQ-017 Latency SHALL be: i_start sampled on edge 1, o_valid high after edge k+2 for lowest set bit k, and after edge BITS+1 for an all-zero word.
REQ-018 Counter width SHALL be $clog2(BITS); the counter SHALL never wrap.
REQ-019 i_arg_A SHALL be treated as unsigned bits; the sign bit is a normal bit at index BITS-1.
REQ-020 i_start in SCAN or DONE SHALL be ignored, with no queuing; i_arg_A changes after sampling SHALL have no effect.
REQ-021 o_result and o_error SHALL hold their values from DONE until the next DONE.
REQ-022 A new request SHALL be accepted at the earliest in the first IDLE cycle after DONE.

Reset
REQ-023 i_rst=1 on any edge SHALL force IDLE, clear shift register and counter, and set o_result=0, o_error=0, o_busy=0, o_valid=0.
REQ-024 Reset SHALL take priority over i_start and over an in-progress scan; an aborted scan SHALL produce no o_valid.
REQ-025 i_start asserted in the same edge as i_rst SHALL be dropped.

Structure
REQ-026 The FSM state enum type (IDLE/SCAN/DONE) SHALL be in the shared ALU package, with a default-BITS constant the ALU top also uses.
REQ-027 No sub-module is required; shift register, counter and FSM SHALL be in one module.
REQ-028 Outputs o_result, o_error and o_valid SHALL be registered; o_busy SHALL be decoded from state.

Verification (BITS=32)
REQ-029 A=0x00000001 with start -> o_valid after edge 2, o_result=0, o_error=0.
REQ-030 A=0x80000050 -> o_result=4, o_error=0, o_valid after edge 6; A=0x80000000 -> o_result=31, o_valid after edge 33.
REQ-031 A=0x00000000 -> o_result=0, o_error=1, o_valid after edge 33, o_busy high on edges 2..33.
REQ-032 Start A=0x00000100, then start A=0x00000001 during SCAN -> single o_valid, o_result=8; second request lost.
REQ-033 Start A=0x00010000, i_rst on edge 5 -> no o_valid, all outputs 0; next start A=0x00000002 -> o_result=1 after edge 3 of the new request.
